// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared states, opcodes and control word for the multicycle controller
package mc_pkg;

  localparam int OPW_DEF = 6;

  typedef enum logic [3:0] {
    FETCH1, FETCH2, FETCH3, FETCH4, DECODE,
    MEMADR, LBRD, LBWR, SBWR,
    RTYPEEX, RTYPEWR, BEQEX, JEX, ADDIEX, ADDIWR
  } state_t;

  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef struct packed {
    logic       memread;
    logic       memwrite;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic       alusrca;
    logic       regwrite;
    logic [3:0] irwrite;
    logic [1:0] alusrcb;
    logic [1:0] pcsource;
    logic [1:0] aluop;
    logic       pcwrite;
    logic       branch;
  } ctrl_t;

endpackage

// File: rtl/mc_if.sv
// rtl/mc_if.sv - controller-to-datapath bus: opcode/zero in, datapath controls out
interface mc_if #(
  parameter int OPW = 6
);
  logic [OPW-1:0] op;
  logic           zero;
  logic           memread;
  logic           memwrite;
  logic           iord;
  logic           memtoreg;
  logic           regdst;
  logic           alusrca;
  logic           regwrite;
  logic [3:0]     irwrite;
  logic [1:0]     alusrcb;
  logic [1:0]     pcsource;
  logic [1:0]     aluop;
  logic           pcen;

  modport master (
    input  op, zero,
    output memread, memwrite, iord, memtoreg, regdst, alusrca, regwrite,
    output irwrite, alusrcb, pcsource, aluop, pcen
  );

  modport slave (
    output op, zero,
    input  memread, memwrite, iord, memtoreg, regdst, alusrca, regwrite,
    input  irwrite, alusrcb, pcsource, aluop, pcen
  );
endinterface

// File: rtl/mc_outdec.sv
// rtl/mc_outdec.sv - Moore decode of controller state into the datapath control word
module mc_outdec
  import mc_pkg::*;
(
  input  state_t state,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      FETCH1, FETCH2, FETCH3, FETCH4: begin
        ctrl.memread = 1'b1;
        ctrl.alusrcb = 2'b01;
        ctrl.pcwrite = 1'b1;
        case (state)
          FETCH1:  ctrl.irwrite = 4'b0001;
          FETCH2:  ctrl.irwrite = 4'b0010;
          FETCH3:  ctrl.irwrite = 4'b0100;
          default: ctrl.irwrite = 4'b1000;
        endcase
      end
      // Branch target is precomputed here so BEQEX only has to compare.
      DECODE:  ctrl.alusrcb = 2'b11;
      MEMADR, ADDIEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = 2'b10;
      end
      LBRD: begin
        ctrl.memread = 1'b1;
        ctrl.iord    = 1'b1;
      end
      LBWR: begin
        ctrl.regwrite = 1'b1;
        ctrl.memtoreg = 1'b1;
      end
      SBWR: begin
        ctrl.memwrite = 1'b1;
        ctrl.iord     = 1'b1;
      end
      RTYPEEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.aluop   = 2'b10;
      end
      RTYPEWR: begin
        ctrl.regwrite = 1'b1;
        ctrl.regdst   = 1'b1;
      end
      ADDIWR:  ctrl.regwrite = 1'b1;
      BEQEX: begin
        ctrl.alusrca  = 1'b1;
        ctrl.aluop    = 2'b01;
        ctrl.pcsource = 2'b01;
        ctrl.branch   = 1'b1;
      end
      JEX: begin
        ctrl.pcsource = 2'b10;
        ctrl.pcwrite  = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multicycle CPU control FSM: state register, next-state logic, PC enable
module mc_controller
  import mc_pkg::*;
#(
  parameter int OPW = OPW_DEF
) (
  input  logic     clk,
  input  logic     reset_n,
  mc_if.master     bus
);

  state_t state_q, state_d;
  logic   is_lb_q, is_lb_d;
  ctrl_t  ctrl;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= FETCH1;
      is_lb_q <= 1'b0;
    end else begin
      state_q <= state_d;
      is_lb_q <= is_lb_d;
    end
  end

  // LB/SB share MEMADR; the choice is latched in DECODE so op is ignored afterwards.
  always_comb begin
    state_d = FETCH1;
    is_lb_d = is_lb_q;
    case (state_q)
      FETCH1:  state_d = FETCH2;
      FETCH2:  state_d = FETCH3;
      FETCH3:  state_d = FETCH4;
      FETCH4:  state_d = DECODE;
      DECODE: begin
        is_lb_d = (bus.op == OPW'(OP_LB));
        if (bus.op == OPW'(OP_LB) || bus.op == OPW'(OP_SB)) state_d = MEMADR;
        else if (bus.op == OPW'(OP_RTYPE))                   state_d = RTYPEEX;
        else if (bus.op == OPW'(OP_BEQ))                     state_d = BEQEX;
        else if (bus.op == OPW'(OP_J))                       state_d = JEX;
        else if (bus.op == OPW'(OP_ADDI))                    state_d = ADDIEX;
        else                                                 state_d = FETCH1;
      end
      MEMADR:  state_d = is_lb_q ? LBRD : SBWR;
      LBRD:    state_d = LBWR;
      RTYPEEX: state_d = RTYPEWR;
      ADDIEX:  state_d = ADDIWR;
      default: state_d = FETCH1;
    endcase
  end

  mc_outdec u_outdec (
    .state (state_q),
    .ctrl  (ctrl)
  );

  assign bus.memread  = ctrl.memread;
  assign bus.memwrite = ctrl.memwrite;
  assign bus.iord     = ctrl.iord;
  assign bus.memtoreg = ctrl.memtoreg;
  assign bus.regdst   = ctrl.regdst;
  assign bus.alusrca  = ctrl.alusrca;
  assign bus.regwrite = ctrl.regwrite;
  assign bus.irwrite  = ctrl.irwrite;
  assign bus.alusrcb  = ctrl.alusrcb;
  assign bus.pcsource = ctrl.pcsource;
  assign bus.aluop    = ctrl.aluop;
  assign bus.pcen     = ctrl.pcwrite | (ctrl.branch & bus.zero);

endmodule

// File: tb/tb_mc_controller.sv
// tb/tb_mc_controller.sv - scoreboard bench for mc_controller instruction sequences
module tb_mc_controller;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  mc_if #(.OPW(6)) bus ();

  mc_controller #(.OPW(6)) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.master)
  );

  typedef enum int {K_LB, K_SB, K_R, K_ADDI, K_BEQ, K_J, K_ILL} kind_t;

  logic [17:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [17:0] obs, input logic [17:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [17:0] vec(input logic mr, mw, iord, mtr, rd, asa, rw,
                                      input logic [3:0] irw, input logic [1:0] asb, pcs, aop,
                                      input logic pcen);
    return {mr, mw, iord, mtr, rd, asa, rw, irw, asb, pcs, aop, pcen};
  endfunction

  function automatic logic [17:0] obs_vec();
    return {bus.memread, bus.memwrite, bus.iord, bus.memtoreg, bus.regdst, bus.alusrca,
            bus.regwrite, bus.irwrite, bus.alusrcb, bus.pcsource, bus.aluop, bus.pcen};
  endfunction

  function automatic int lat(input kind_t k);
    case (k)
      K_LB:                 return 8;
      K_SB, K_R, K_ADDI:    return 7;
      K_BEQ, K_J:           return 6;
      default:              return 5;
    endcase
  endfunction

  function automatic logic [5:0] opc(input kind_t k);
    case (k)
      K_LB:    return 6'b100000;
      K_SB:    return 6'b101000;
      K_R:     return 6'b000000;
      K_ADDI:  return 6'b001000;
      K_BEQ:   return 6'b000100;
      K_J:     return 6'b000010;
      default: return 6'b111111;
    endcase
  endfunction

  function automatic logic [17:0] fetch1_vec();
    return vec(1, 0, 0, 0, 0, 0, 0, 4'b0001, 2'b01, 2'b00, 2'b00, 1);
  endfunction

  function automatic logic [17:0] exp_vec(input kind_t k, input int s, input logic z);
    if (s < 4) return vec(1, 0, 0, 0, 0, 0, 0, 4'(1 << s), 2'b01, 2'b00, 2'b00, 1);
    if (s == 4) return vec(0, 0, 0, 0, 0, 0, 0, 4'b0000, 2'b11, 2'b00, 2'b00, 0);
    case (k)
      K_LB: begin
        if (s == 5) return vec(0, 0, 0, 0, 0, 1, 0, 4'b0, 2'b10, 2'b00, 2'b00, 0);
        if (s == 6) return vec(1, 0, 1, 0, 0, 0, 0, 4'b0, 2'b00, 2'b00, 2'b00, 0);
        return vec(0, 0, 0, 1, 0, 0, 1, 4'b0, 2'b00, 2'b00, 2'b00, 0);
      end
      K_SB: begin
        if (s == 5) return vec(0, 0, 0, 0, 0, 1, 0, 4'b0, 2'b10, 2'b00, 2'b00, 0);
        return vec(0, 1, 1, 0, 0, 0, 0, 4'b0, 2'b00, 2'b00, 2'b00, 0);
      end
      K_R: begin
        if (s == 5) return vec(0, 0, 0, 0, 0, 1, 0, 4'b0, 2'b00, 2'b00, 2'b10, 0);
        return vec(0, 0, 0, 0, 1, 0, 1, 4'b0, 2'b00, 2'b00, 2'b00, 0);
      end
      K_ADDI: begin
        if (s == 5) return vec(0, 0, 0, 0, 0, 1, 0, 4'b0, 2'b10, 2'b00, 2'b00, 0);
        return vec(0, 0, 0, 0, 0, 0, 1, 4'b0, 2'b00, 2'b00, 2'b00, 0);
      end
      K_BEQ:   return vec(0, 0, 0, 0, 0, 1, 0, 4'b0, 2'b00, 2'b01, 2'b01, z);
      K_J:     return vec(0, 0, 0, 0, 0, 0, 0, 4'b0, 2'b00, 2'b10, 2'b00, 1);
      default: return 18'h0;
    endcase
  endfunction

  // Starts in FETCH1; with abort_at >= 0, reset_n is pulled low for two edges from that step.
  task automatic run_instr(input kind_t k, input logic z, input int abort_at);
    int n;
    int rw_cnt;
    logic both;
    n = lat(k);
    rw_cnt = 0;
    both = 1'b0;
    for (int s = 0; s < n; s++) exp_q.push_back(exp_vec(k, s, z));
    for (int s = 0; s < n; s++) begin
      @(negedge clk);
      reset_n  = (s == abort_at) ? 1'b0 : 1'b1;
      bus.op   = (s == 4) ? opc(k) : 6'($urandom);
      bus.zero = (k == K_BEQ && s == 5) ? z : 1'($urandom);
      #1;
      check($sformatf("%s_z%0d_step%0d", k.name(), z, s), obs_vec(), exp_q.pop_front());
      rw_cnt += int'(bus.regwrite);
      both |= bus.regwrite & bus.memwrite;
      if (s == abort_at) break;
    end
    if (abort_at >= 0) begin
      exp_q.delete();
      @(negedge clk);
      bus.op   = 6'($urandom);
      bus.zero = 1'($urandom);
      #1;
      check($sformatf("%s_abort_fetch1", k.name()), obs_vec(), fetch1_vec());
      check($sformatf("%s_abort_wr", k.name()), 18'({bus.regwrite, bus.memwrite}), 18'h0);
    end else begin
      check($sformatf("%s_rw_count", k.name()), 18'(rw_cnt),
            (k == K_LB || k == K_R || k == K_ADDI) ? 18'd1 : 18'd0);
      check($sformatf("%s_rw_mw_overlap", k.name()), 18'(both), 18'h0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.op   = 6'b0;
    bus.zero = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("reset_state", obs_vec(), fetch1_vec());

    run_instr(K_LB,   1'b0, -1);
    run_instr(K_SB,   1'b0, -1);
    run_instr(K_R,    1'b0, -1);
    run_instr(K_ADDI, 1'b0, -1);
    run_instr(K_BEQ,  1'b1, -1);
    run_instr(K_BEQ,  1'b0, -1);
    run_instr(K_J,    1'b0, -1);
    run_instr(K_ILL,  1'b0, -1);
    run_instr(K_LB,   1'b0, 5);
    run_instr(K_R,    1'b0, 6);
    run_instr(K_SB,   1'b0, 6);
    run_instr(K_ADDI, 1'b0, -1);
    repeat (12) run_instr(kind_t'($urandom_range(0, 6)), 1'($urandom), -1);

    check("scoreboard_empty", 18'(exp_q.size()), 18'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
